// File: rtl/rgb2ycbcr_seq.sv
// rgb2ycbcr_seq: feeds the RGB->YCbCr converter one block at a time.
// The converter `enable` is held high for the whole block, so it stays high
// after every pixel. Upstream stalls become untagged bubbles. A tag pipeline
// matched to the converter latency frames the converter output into blocks
// and frames.
//
// Handshake: an upstream transfer happens on a rising edge where
// s_valid && s_ready. s_ready is decoded only from the registered state.
// The output stream (m_valid) has no backpressure. Downstream grants a whole
// block in advance through blk_free.
module rgb2ycbcr_seq #(
    parameter int BLOCK_PIXELS     = 64,
    parameter int BLOCKS_PER_FRAME = 4800,
    parameter int CONV_LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [23:0] s_data,
    output logic        s_ready,
    input  logic        blk_free,
    output logic        conv_enable,
    output logic [23:0] conv_data,
    input  logic [23:0] conv_data_out,
    input  logic        conv_enable_out,
    output logic        m_valid,
    output logic [23:0] m_data,
    output logic        m_first,
    output logic        m_last,
    output logic        m_sof,
    output logic        m_eof,
    output logic        busy,
    output logic        err_align,
    output logic [1:0]  dbg_state
);

    localparam int PIX_W = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
    localparam int BLK_W = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(BLOCK_PIXELS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCKS_PER_FRAME - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Tag bit positions: {valid, first, last, sof, eof}
    localparam int T_VALID = 4;
    localparam int T_FIRST = 3;
    localparam int T_LAST  = 2;
    localparam int T_SOF   = 1;
    localparam int T_EOF   = 0;

    logic [1:0]       state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [4:0]       tag_d;
    logic [4:0]       tag_q [CONV_LATENCY];
    logic             err_align_q;
    logic             is_first, is_last, blk_first, blk_is_last;
    logic             any_tag_valid;
    logic [4:0]       tag_out;

    assign is_first    = (pix_cnt_q == '0);
    assign is_last     = (pix_cnt_q == PIX_LAST);
    assign blk_first   = (blk_cnt_q == '0);
    assign blk_is_last = (blk_cnt_q == BLK_LAST);

    // Next-state, counters and the stage-0 tag for this cycle's slot
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        blk_cnt_d = blk_cnt_q;
        tag_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (blk_free) begin
                    state_d   = ST_RUN;
                    pix_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (s_valid) begin
                    tag_d     = {1'b1, is_first, is_last,
                                 is_first && blk_first, is_last && blk_is_last};
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    if (is_last) begin
                        pix_cnt_d = '0;
                        blk_cnt_d = blk_is_last ? '0 : blk_cnt_q + BLK_W'(1);
                        // blk_free only matters here and in IDLE; a mid-block drop is ignored
                        if (!blk_free) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and pixel/block counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pix_cnt_q <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Tag pipeline: shifts every cycle to stay aligned with the converter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CONV_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[CONV_LATENCY-1];

    // Sticky flag: a tagged slot arrived but the converter reported no output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_align_q <= 1'b0;
        end else if (tag_out[T_VALID] && !conv_enable_out) begin
            err_align_q <= 1'b1;
        end
    end

    // Any pixel still travelling through the converter keeps the block busy
    always_comb begin
        any_tag_valid = 1'b0;
        for (int i = 0; i < CONV_LATENCY; i++) begin
            any_tag_valid = any_tag_valid | tag_q[i][T_VALID];
        end
    end

    assign s_ready     = (state_q == ST_RUN);
    assign conv_enable = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign conv_data   = s_data;

    assign m_valid   = tag_out[T_VALID] && conv_enable_out;
    assign m_data    = conv_data_out;
    assign m_first   = tag_out[T_FIRST] && m_valid;
    assign m_last    = tag_out[T_LAST]  && m_valid;
    assign m_sof     = tag_out[T_SOF]   && m_valid;
    assign m_eof     = tag_out[T_EOF]   && m_valid;
    assign busy      = (state_q != ST_IDLE) || any_tag_valid;
    assign err_align = err_align_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rgb2ycbcr_seq.sv
// tb_rgb2ycbcr_seq: scoreboard bench for the block sequencer. It uses a
// behavioural 3-cycle converter. It frames the expected stream by counting
// accepted pixels.
module tb_rgb2ycbcr_seq;

  localparam int BP  = 64;
  localparam int BPF = 2;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_ready;
  logic        blk_free = 1'b0;
  logic        conv_enable;
  logic [23:0] conv_data;
  logic [23:0] conv_data_out;
  logic        conv_enable_out;
  logic        m_valid, m_first, m_last, m_sof, m_eof, busy, err_align;
  logic [23:0] m_data;
  logic [1:0]  dbg_state;

  rgb2ycbcr_seq #(.BLOCK_PIXELS(BP), .BLOCKS_PER_FRAME(BPF), .CONV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .blk_free(blk_free), .conv_enable(conv_enable), .conv_data(conv_data),
    .conv_data_out(conv_data_out), .conv_enable_out(conv_enable_out),
    .m_valid(m_valid), .m_data(m_data), .m_first(m_first), .m_last(m_last),
    .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .err_align(err_align),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural converter ----------------
  function automatic logic [23:0] ycc(input logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[7:0]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[23:16]);
    y  = (77 * r + 150 * g + 29 * b) / 256;
    cb = 128 + (-43 * r - 85 * g + 128 * b) / 256;
    cr = 128 + (128 * r - 107 * g - 21 * b) / 256;
    if (cb < 0) cb = 0;
    if (cb > 255) cb = 255;
    if (cr < 0) cr = 0;
    if (cr > 255) cr = 255;
    if (y > 255) y = 255;
    return {cr[7:0], cb[7:0], y[7:0]};
  endfunction

  logic        conv_kill = 1'b0;
  logic [2:0]  c_en, c_kill;
  logic [23:0] c_dat [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_en <= '0;
      c_kill <= '0;
      for (int i = 0; i < 3; i++) c_dat[i] <= '0;
    end else begin
      c_en   <= {c_en[1:0], conv_enable};
      c_kill <= {c_kill[1:0], conv_kill};
      c_dat[0] <= conv_data;
      c_dat[1] <= c_dat[0];
      c_dat[2] <= c_dat[1];
    end
  end

  assign conv_enable_out = c_en[2] & ~c_kill[2];
  assign conv_data_out   = ycc(c_dat[2]);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic        drop;
    logic        first;
    logic        last;
    logic        sof;
    logic        eof;
    logic [23:0] raw;
    logic [23:0] data;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: framing follows purely from the count of accepted pixels
  int mdl_pix = 0;
  int mdl_blk = 0;

  function automatic exp_t model_accept(input logic [23:0] rgb, input logic drop, input int now);
    exp_t e;
    e.due   = 32'(now + LAT);
    e.drop  = drop;
    e.raw   = rgb;
    e.data  = ycc(rgb);
    e.first = (mdl_pix == 0);
    e.last  = (mdl_pix == BP - 1);
    e.sof   = e.first && (mdl_blk == 0);
    e.eof   = e.last && (mdl_blk == BPF - 1);
    mdl_pix++;
    if (mdl_pix == BP) begin
      mdl_pix = 0;
      mdl_blk = (mdl_blk + 1) % BPF;
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic prev_acc = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) check("enable_after_pixel", 32'(conv_enable), 32'd1);
      if (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
        mon_e = exp_q.pop_front();
        if (int'(mon_e.due) < cyc) begin
          check("missing_output", 32'd0, 32'd1);
        end else if (mon_e.drop) begin
          check("killed_slot_valid", 32'(m_valid), 32'd0);
        end else begin
          check("m_valid", 32'(m_valid), 32'd1);
          check("m_data", 32'(m_data), 32'(mon_e.data));
          check("m_flags", 32'({m_first, m_last, m_sof, m_eof}),
                32'({mon_e.first, mon_e.last, mon_e.sof, mon_e.eof}));
          if (mon_e.raw == 24'h808080) check("gray_pixel", 32'(m_data), 32'h808080);
        end
      end else begin
        check("stray_output", 32'({m_valid, m_first, m_last, m_sof, m_eof}), 32'd0);
      end
      prev_acc = s_valid && s_ready;
    end
  end

  // ---------------- driver tasks ----------------
  logic gray_first = 1'b0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;

  task automatic drive(input int n, input int pct, input int free_off_at, input int kill_at);
    int acc = 0;
    int budget = 0;
    exp_t e;
    while (acc < n && budget < 4000) begin
      @(posedge clk); #1;
      conv_kill = 1'b0;
      if (acc == free_off_at) blk_free = 1'b0;
      s_valid = ($urandom_range(99) < pct);
      s_data  = (acc == 0 && gray_first) ? 24'h808080 : 24'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) begin
        e = model_accept(s_data, acc == kill_at, cyc);
        exp_q.push_back(e);
        if (acc == kill_at) conv_kill = 1'b1;
        if (acc == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc++;
      end
      budget++;
    end
    if (acc < n) check("accept_timeout", 32'(acc), 32'(n));
    @(posedge clk); #1;
    s_valid = 1'b0;
    conv_kill = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic grant_block();
    @(posedge clk); #1;
    blk_free = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    mdl_pix = 0;
    mdl_blk = 0;
    @(negedge clk);
    check("reset_outputs",
          32'({s_ready, conv_enable, m_valid, m_first, m_last, m_sof, m_eof, busy, err_align}),
          32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();

    // Three back-to-back blocks; blk_free drops mid third block and is ignored
    gray_first = 1'b1;
    grant_block();
    drive(3 * BP, 100, 2 * BP + 20, -1);
    gray_first = 1'b0;
    check("gapless_span", 32'(last_acc_cyc - first_acc_cyc), 32'(3 * BP - 1));
    @(negedge clk);
    check("flush_ready", 32'(s_ready), 32'd0);
    check("flush_enable", 32'(conv_enable), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_ready", 32'({s_ready, conv_enable}), 32'd0);
    end
    check("idle_busy", 32'(busy), 32'd0);

    // IDLE->RUN latency, then a block with upstream bubbles
    grant_block();
    @(negedge clk);
    check("grant_cycle_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    blk_free = 1'b0;
    @(negedge clk);
    check("grant_next_ready", 32'(s_ready), 32'd1);
    drive(BP, 50, 0, -1);
    idle_cycles(6);
    check("bubble_err_align", 32'(err_align), 32'd0);
    check("bubble_busy", 32'(busy), 32'd0);

    // Reset mid-block, then a fresh block must restart framing
    grant_block();
    drive(20, 100, 0, -1);
    do_reset();
    grant_block();
    drive(BP, 100, 0, -1);
    idle_cycles(6);

    // Converter drops one tagged slot
    grant_block();
    drive(BP, 100, 0, $urandom_range(BP - 1));
    idle_cycles(6);
    check("err_align_set", 32'(err_align), 32'd1);
    idle_cycles(5);
    check("err_align_sticky", 32'(err_align), 32'd1);
    do_reset();
    check("err_align_cleared", 32'(err_align), 32'd0);

    idle_cycles(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
